// File: rtl/inst_prefetch_buffer_pkg.sv
// Shared definitions for the instruction prefetch buffer: FSM encoding and
// default sizing used by the pipeline fetch path.
package inst_prefetch_buffer_pkg;

    localparam int PF_DEPTH_DEFAULT  = 4;
    localparam int PF_ADDR_W_DEFAULT = 32;
    localparam int INST_W            = 32;

    typedef enum logic [1:0] {
        PF_IDLE  = 2'd0,
        PF_REQ   = 2'd1,
        PF_DRAIN = 2'd2
    } pf_state_e;

endpackage

// File: rtl/inst_prefetch_buffer_if.sv
// Fetch-side and memory-side signals of the prefetch buffer. The slave modport
// is the buffer itself; the master modport is the pipeline/memory environment.
interface inst_prefetch_buffer_if #(
    parameter int ADDR_W = 32
);
    import inst_prefetch_buffer_pkg::*;

    logic              inst_ren;
    logic [ADDR_W-1:0] inst_addr;
    logic [INST_W-1:0] inst_data;
    logic              inst_hit;
    logic              if_stall;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [INST_W-1:0] mem_rdata;

    modport slave (
        input  inst_ren, inst_addr, mem_ack, mem_rdata,
        output inst_data, inst_hit, if_stall, mem_req, mem_addr
    );

    modport master (
        output inst_ren, inst_addr, mem_ack, mem_rdata,
        input  inst_data, inst_hit, if_stall, mem_req, mem_addr
    );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue storage: DEPTH {addr, data} entries in FIFO order with
// power-of-two wrapping pointers and a single-cycle flush.
module fetch_fifo
    import inst_prefetch_buffer_pkg::*;
#(
    parameter int DEPTH  = PF_DEPTH_DEFAULT,
    parameter int ADDR_W = PF_ADDR_W_DEFAULT,
    parameter int DATA_W = INST_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [DATA_W-1:0] push_data_i,
    output logic [ADDR_W-1:0] head_addr_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              wr_en;
    logic              rd_en;

    always_comb begin
        full_o      = (count_q == CNT_W'(DEPTH));
        empty_o     = (count_q == '0);
        wr_en       = push_i & ~full_o;
        rd_en       = pop_i & ~empty_o;
        head_addr_o = addr_mem_q[rd_ptr_q];
        head_data_o = data_mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_q[i] <= '0;
                data_mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                addr_mem_q[wr_ptr_q] <= push_addr_i;
                data_mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q             <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/inst_prefetch_buffer.sv
// Sequential instruction prefetcher: fills fetch_fifo from instruction memory
// and serves IF-stage fetches from the queue head, flushing on a redirect.
//
// state | meaning
// IDLE  | no memory request outstanding
// REQ   | mem_req high; the response will be enqueued
// DRAIN | mem_req high; the response is stale and will be dropped
module inst_prefetch_buffer
    import inst_prefetch_buffer_pkg::*;
#(
    parameter int DEPTH  = PF_DEPTH_DEFAULT,
    parameter int ADDR_W = PF_ADDR_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    inst_prefetch_buffer_if.slave  bus
);
    pf_state_e         state_q;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W-1:0] pf_addr_q;
    logic [ADDR_W-1:0] pf_addr_d;

    logic [ADDR_W-1:0] head_addr;
    logic [INST_W-1:0] head_data;
    logic              fifo_full;
    logic              fifo_empty;

    logic              hit;
    logic              outstanding_match;
    logic              redirect;
    logic              push;
    logic              launch;

    // A request already in flight for the wanted address is not a redirect.
    always_comb begin
        hit               = bus.inst_ren & ~fifo_empty & (head_addr == bus.inst_addr);
        outstanding_match = (state_q != PF_IDLE) & (mem_addr_q == bus.inst_addr);
        redirect          = bus.inst_ren & ~hit &
                            (~fifo_empty | ((bus.inst_addr != pf_addr_q) & ~outstanding_match));
        push              = (state_q == PF_REQ) & bus.mem_ack & ~redirect;
        launch            = (state_q == PF_IDLE) & ~fifo_full & ~redirect;

        pf_addr_d = pf_addr_q;
        if (redirect) begin
            pf_addr_d = bus.inst_addr;
        end else if (push) begin
            pf_addr_d = pf_addr_q + ADDR_W'(4);
        end
    end

    assign bus.inst_hit  = hit;
    assign bus.inst_data = hit ? head_data : '0;
    assign bus.if_stall  = bus.inst_ren & ~hit;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PF_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            pf_addr_q  <= '0;
        end else begin
            pf_addr_q <= pf_addr_d;
            case (state_q)
                PF_IDLE: begin
                    if (launch) begin
                        state_q    <= PF_REQ;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= pf_addr_q;
                    end
                end
                PF_REQ: begin
                    if (bus.mem_ack) begin
                        state_q   <= PF_IDLE;
                        mem_req_q <= 1'b0;
                    end else if (redirect) begin
                        state_q <= PF_DRAIN;
                    end
                end
                PF_DRAIN: begin
                    if (bus.mem_ack) begin
                        state_q   <= PF_IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= PF_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (INST_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .pop_i       (hit),
        .flush_i     (redirect),
        .push_addr_i (mem_addr_q),
        .push_data_i (bus.mem_rdata),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

endmodule
